// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Lookup is combinational from the fetch PC; training happens from the resolved branch slot.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_next_pc,
   input  logic        inv_all,
   output logic        mispredict,
   output logic [31:0] cnt_updates,
   output logic [31:0] cnt_mispred
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = IDX_W + TAG_W + 1;

   // Weakly taken is MSB set, rest clear; weakly not-taken is one below it.
   localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1 << (CNT_W - 1));
   localparam logic [CNT_W-1:0] CTR_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [CNT_W-1:0] ctr_q    [ENTRIES];
   logic [31:0]      cnt_updates_q, cnt_updates_d;
   logic [31:0]      cnt_mispred_q, cnt_mispred_d;

   logic [IDX_W-1:0] idx_if, upd_idx;
   logic [TAG_W-1:0] tag_if, upd_tag;
   logic             hit_if, upd_hit, tbl_we;
   logic [CNT_W-1:0] ctr_d;
   logic [31:0]      target_d;

   assign idx_if  = pc_if[TAG_LO-1:2];
   assign tag_if  = pc_if[TAG_HI:TAG_LO];
   assign upd_idx = upd_pc[TAG_LO-1:2];
   assign upd_tag = upd_pc[TAG_HI:TAG_LO];

   assign hit_if       = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
   assign pred_taken   = hit_if && ctr_q[idx_if][CNT_W-1];
   assign pred_next_pc = pred_taken ? target_q[idx_if] : pc_if + 32'd4;

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_next_pc)));

   assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign tbl_we   = upd_valid && !inv_all && (upd_hit || upd_taken);
   assign ctr_d    = upd_hit ? (upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]))
                             : CTR_WT;
   assign target_d = upd_taken ? upd_target : target_q[upd_idx];

   assign cnt_updates_d = cnt_updates_q + {31'd0, upd_valid};
   assign cnt_mispred_d = cnt_mispred_q + {31'd0, mispredict};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         cnt_updates_q <= '0;
         cnt_mispred_q <= '0;
      end else begin
         cnt_updates_q <= cnt_updates_d;
         cnt_mispred_q <= cnt_mispred_d;
         // Invalidation wins over training; the event is still counted above.
         if (inv_all) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
         end else if (tbl_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= target_d;
            ctr_q[upd_idx]    <= ctr_d;
         end
      end
   end

   assign cnt_updates = cnt_updates_q;
   assign cnt_mispred = cnt_mispred_q;

   logic unused_lo;
   assign unused_lo = ^{pc_if[1:0], upd_pc[1:0]};
   if (TAG_HI < 31) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{pc_if[31:TAG_HI+1], upd_pc[31:TAG_HI+1]};
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor at default parameters (16 entries, 8-bit tag, 2-bit counters).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_if = '0;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [31:0] upd_pred_next_pc = '0;
   logic        inv_all = 1'b0;
   logic        mispredict;
   logic [31:0] cnt_updates;
   logic [31:0] cnt_mispred;

   int errors = 0;
   int checks = 0;

   branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .pc_if(pc_if),
      .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_next_pc(upd_pred_next_pc), .inv_all(inv_all),
      .mispredict(mispredict), .cnt_updates(cnt_updates), .cnt_mispred(cnt_mispred)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] pnpc);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_pred_taken = ptk; upd_pred_next_pc = pnpc;
   endtask

   task automatic idle_upd();
      upd_valid = 1'b0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pc_if = 32'h40;
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h44) begin errors++; $display("FAIL reset_next_pc: got %h want 00000044", pred_next_pc); end
      checks++; if (cnt_updates !== 32'd0) begin errors++; $display("FAIL reset_cnt_updates: got %0d want 0", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd0) begin errors++; $display("FAIL reset_cnt_mispred: got %0d want 0", cnt_mispred); end
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", mispredict); end
   endtask

   task automatic test_allocate();
      pc_if = 32'h40;
      drive_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      #1;
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict); end
      tick();
      idle_upd();
      #1;
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h100) begin errors++; $display("FAIL alloc_next_pc: got %h want 00000100", pred_next_pc); end
      checks++; if (cnt_mispred !== 32'd1) begin errors++; $display("FAIL alloc_cnt_mispred: got %0d want 1", cnt_mispred); end
      checks++; if (cnt_updates !== 32'd1) begin errors++; $display("FAIL alloc_cnt_updates: got %0d want 1", cnt_updates); end
   endtask

   // Back-to-back updates at 0x40: ctr 10 -> 01 -> 00 -> 00 -> 01 -> 10.
   task automatic test_saturation();
      logic       tk_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       ptk_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       mis_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       pt_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] npc_v [5] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h100};
      pc_if = 32'h40;
      for (int i = 0; i < 5; i++) begin
         drive_upd(32'h40, tk_v[i], 32'h100, ptk_v[i], ptk_v[i] ? 32'h100 : 32'h44);
         #1;
         checks++; if (mispredict !== mis_v[i]) begin errors++; $display("FAIL sat_mispredict[%0d]: got %0b want %0b", i, mispredict, mis_v[i]); end
         tick();
         checks++; if (pred_taken !== pt_v[i]) begin errors++; $display("FAIL sat_pred_taken[%0d]: got %0b want %0b", i, pred_taken, pt_v[i]); end
         checks++; if (pred_next_pc !== npc_v[i]) begin errors++; $display("FAIL sat_next_pc[%0d]: got %h want %h", i, pred_next_pc, npc_v[i]); end
      end
      idle_upd();
      #1;
      checks++; if (cnt_updates !== 32'd6) begin errors++; $display("FAIL sat_cnt_updates: got %0d want 6", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd4) begin errors++; $display("FAIL sat_cnt_mispred: got %0d want 4", cnt_mispred); end
   endtask

   task automatic test_aliasing();
      pc_if = 32'h80;
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h84) begin errors++; $display("FAIL alias_miss_next_pc: got %h want 00000084", pred_next_pc); end
      drive_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle_upd();
      #1;
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_hit_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h200) begin errors++; $display("FAIL alias_hit_next_pc: got %h want 00000200", pred_next_pc); end
      pc_if = 32'h40;
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h44) begin errors++; $display("FAIL alias_evicted_next_pc: got %h want 00000044", pred_next_pc); end
      checks++; if (cnt_mispred !== 32'd5) begin errors++; $display("FAIL alias_cnt_mispred: got %0d want 5", cnt_mispred); end
   endtask

   task automatic test_same_cycle();
      pc_if = 32'h40;
      drive_upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h44) begin errors++; $display("FAIL same_cycle_old_next_pc: got %h want 00000044", pred_next_pc); end
      tick();
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_new_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h300) begin errors++; $display("FAIL same_cycle_new_next_pc: got %h want 00000300", pred_next_pc); end
      // Correctly predicted taken update: ctr 10 -> 11.
      drive_upd(32'h40, 1'b1, 32'h300, 1'b1, 32'h300);
      #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL correct_pred_mispredict: got %0b want 0", mispredict); end
      tick();
      checks++; if (cnt_updates !== 32'd9) begin errors++; $display("FAIL correct_pred_cnt_updates: got %0d want 9", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd6) begin errors++; $display("FAIL correct_pred_cnt_mispred: got %0d want 6", cnt_mispred); end
      // Not-taken predicted not-taken, stale target fields: never a mispredict. ctr 11 -> 10.
      drive_upd(32'h40, 1'b0, 32'h999, 1'b0, 32'h44);
      #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nt_nt_mispredict: got %0b want 0", mispredict); end
      tick();
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL nt_nt_still_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h300) begin errors++; $display("FAIL nt_nt_target_kept: got %h want 00000300", pred_next_pc); end
      // Direction right but target wrong is a mispredict.
      drive_upd(32'h40, 1'b1, 32'h300, 1'b1, 32'h304);
      #1;
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL bad_target_mispredict: got %0b want 1", mispredict); end
      tick();
      idle_upd();
      #1;
      checks++; if (cnt_updates !== 32'd11) begin errors++; $display("FAIL bad_target_cnt_updates: got %0d want 11", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd7) begin errors++; $display("FAIL bad_target_cnt_mispred: got %0d want 7", cnt_mispred); end
   endtask

   task automatic test_invalidate();
      pc_if = 32'h40;
      inv_all = 1'b1;
      drive_upd(32'h40, 1'b1, 32'h400, 1'b1, 32'h300);
      #1;
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL inv_mispredict: got %0b want 1", mispredict); end
      tick();
      inv_all = 1'b0;
      idle_upd();
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL inv_miss_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h44) begin errors++; $display("FAIL inv_miss_next_pc: got %h want 00000044", pred_next_pc); end
      checks++; if (cnt_updates !== 32'd12) begin errors++; $display("FAIL inv_cnt_updates: got %0d want 12", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd8) begin errors++; $display("FAIL inv_cnt_mispred: got %0d want 8", cnt_mispred); end
      // Learn again, then reset with a concurrent update.
      pc_if = 32'h80;
      drive_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle_upd();
      #1;
      checks++; if (pred_next_pc !== 32'h200) begin errors++; $display("FAIL relearn_next_pc: got %h want 00000200", pred_next_pc); end
      rst = 1'b1;
      drive_upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h44);
      tick();
      rst = 1'b0;
      idle_upd();
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_0x80_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h84) begin errors++; $display("FAIL rst_0x80_next_pc: got %h want 00000084", pred_next_pc); end
      pc_if = 32'h40;
      #1;
      checks++; if (pred_next_pc !== 32'h44) begin errors++; $display("FAIL rst_0x40_next_pc: got %h want 00000044", pred_next_pc); end
      checks++; if (cnt_updates !== 32'd0) begin errors++; $display("FAIL rst_cnt_updates: got %0d want 0", cnt_updates); end
      checks++; if (cnt_mispred !== 32'd0) begin errors++; $display("FAIL rst_cnt_mispred: got %0d want 0", cnt_mispred); end
   endtask

   // Lookup wraps at the top of the address space.
   task automatic test_wrap();
      pc_if = 32'hFFFF_FFFC;
      #1;
      checks++; if (pred_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h want 00000000", pred_next_pc); end
   endtask

   initial begin
      tick();
      test_reset();
      test_allocate();
      test_saturation();
      test_aliasing();
      test_same_cycle();
      test_invalidate();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
